bca_arbiter: RTL and testbench
==============================

BCA_ARBITER -- requirements
Module: bca_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
REQ-003 req  in  2  per-requester request; req[i] held high with data_i stable until grant[i] seen.
REQ-004 data0  in  8  operand of requester 0.
REQ-005 data1  in  8  operand of requester 1.
REQ-006 grant  out  2  one-hot accept strobe, high for exactly the cycle the operand is captured.
REQ-007 resp_valid  out  1  result available; held until accepted.
REQ-008 resp_ready  in  1  consumer accepts result on a cycle where resp_valid=1.
REQ-009 resp_id  out  1  index of the requester whose result is presented.
REQ-010 result  out  4  number of 1 bits in the captured operand (0..8).
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, RUN, RESP.
REQ-013 IDLE: if any req bit is high, assert grant for the chosen requester (combinational), load its operand into the engine, clear count, latch resp_id, and go to RUN; otherwise stay.
REQ-014 Arbitration SHALL be round-robin: with both req high, grant the requester not served last; with one req high, grant it.
REQ-015 RUN: if shift register == 0, go to RESP; else shift right by 1 and add shreg[0] to count (one bit per cycle).
REQ-016 RESP: resp_valid=1, result=count, resp_id stable; on resp_ready=1, go to IDLE; otherwise hold all outputs.
REQ-017 Latency: with grant at cycle t, resp_valid first rises at cycle t+k+2, where k = (MSB index of operand)+1 (k=0 for operand 0); operand 0 gives t+2 and operand 0xFF gives t+10.
REQ-018 result SHALL read 0 outside RESP; count SHALL be 4 bits wide and never wrap (max 8).
REQ-019 Requests arriving during RUN/RESP SHALL NOT be granted until the FSM is back in IDLE; no grant in the same cycle as resp_ready acceptance.
REQ-020 A req dropped before its grant SHALL be ignored without side effects; a req still high after grant is a new request.
REQ-021 The round-robin pointer SHALL update only on grant.

Reset
REQ-022 On reset=0: state=IDLE; grant=0, resp_valid=0, resp_id=0, result=0, busy=0; engine shift register and count=0; the RR pointer is set so requester 0 wins the first contention.
REQ-023 Reset asserted mid-RUN or mid-RESP SHALL abort the operation with no response issued; the aborted requester must re-request.

Configuration
REQ-024 Macro BCA_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the pointer is absent; when undefined, round-robin per REQ-014 applies.

Structure
REQ-025 Package bca_pkg SHALL hold DATA_W=8, CNT_W=4, NUM_REQ=2, and the state enum typedef {IDLE, RUN, RESP}.
REQ-026 Shift register, count, and zero flag SHALL live in sub-module bca_engine (load, shift, operand in; zero flag, count out); bca_arbiter holds the FSM and the arbiter.

Verification
REQ-027 req=01, data0=0x00 -> grant=01 at t; resp_valid at t+2 with result=0, resp_id=0.
REQ-028 req=10, data1=0xFF, resp_ready=1 -> resp_valid at t+10 with result=8, resp_id=1; IDLE at t+11.
REQ-029 req=11 held, data0=0x0F, data1=0x81, resp_ready=1 -> first grant=01 (result 4), next grant=10 (result 2), then 01 again.
REQ-030 resp_ready=0 for 5 cycles in RESP with req=01 pending -> resp_valid, result, and resp_id stable; no grant until one cycle after acceptance.
REQ-031 reset=0 two cycles after grant of data0=0xF0 -> all outputs 0 immediately, busy=0; no resp_valid follows.
REQ-032 With BCA_ARB_FIXED_PRIO_EN and req=11 held -> grant=01 on every acceptance.

Source files
------------

// File: rtl/bca_pkg.sv
// Shared parameters, FSM state type and round-robin pick helper for the bit-count arbiter.
package bca_pkg;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Both requesting: the one not served last wins. last=1 means requester 1 was served last.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic last);
        logic [NUM_REQ-1:0] g;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bca_engine.sv
// Bit-serial population-count engine: shifts the operand right one bit per cycle and
// accumulates the bits shifted out. zero flags an exhausted shift register.
module bca_engine
    import bca_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] operand,
    output logic              zero,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] shreg_r;
    logic [CNT_W-1:0]  count_r;

    // Shift register and bit accumulator; count tops out at DATA_W so it cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r <= {DATA_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            shreg_r <= operand;
            count_r <= {CNT_W{1'b0}};
        end else if (shift) begin
            shreg_r <= {1'b0, shreg_r[DATA_W-1:1]};
            count_r <= count_r + {{(CNT_W-1){1'b0}}, shreg_r[0]};
        end else begin
            shreg_r <= shreg_r;
            count_r <= count_r;
        end
    end

    // Status outputs straight from the registers.
    always_comb begin
        zero  = (shreg_r == {DATA_W{1'b0}});
        count = count_r;
    end

endmodule

// File: rtl/bca_arbiter.sv
// Two-requester arbiter in front of a bit-count engine. Round-robin by default;
// defining BCA_ARB_FIXED_PRIO_EN gives requester 0 fixed priority and drops the pointer.
module bca_arbiter
    import bca_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [7:0]        data0,
    input  logic [7:0]        data1,
    output logic [1:0]        grant,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [3:0]        result,
    output logic              busy
);

    state_t              state_r;
    state_t              state_s;
    logic [NUM_REQ-1:0]  pick_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic                load_s;
    logic                shift_s;
    logic [DATA_W-1:0]   operand_s;
    logic                zero_s;
    logic [CNT_W-1:0]    count_s;
    logic                id_r;

`ifdef BCA_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 always wins contention.
    always_comb begin
        if (req[0]) begin
            pick_s = 2'b01;
        end else if (req[1]) begin
            pick_s = 2'b10;
        end else begin
            pick_s = 2'b00;
        end
    end
`else
    logic last_r;

    // Round-robin pointer: reset to "requester 1 served last" so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= 1'b1;
        end else if (load_s) begin
            last_r <= pick_s[1];
        end else begin
            last_r <= last_r;
        end
    end

    // Round-robin selection.
    always_comb begin
        pick_s = rr_pick(req, last_r);
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched id of the requester being served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_r <= 1'b0;
        end else if (load_s) begin
            id_r <= pick_s[1];
        end else begin
            id_r <= id_r;
        end
    end

    // Next-state and engine control.
    always_comb begin
        state_s = state_r;
        grant_s = 2'b00;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s != 2'b00) begin
                    grant_s = pick_s;
                    load_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (zero_s) begin
                    state_s = RESP;
                end else begin
                    shift_s = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand mux follows the winner.
    always_comb begin
        if (pick_s[1]) begin
            operand_s = data1;
        end else begin
            operand_s = data0;
        end
    end

    bca_engine u_engine (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .shift   (shift_s),
        .operand (operand_s),
        .zero    (zero_s),
        .count   (count_s)
    );

    // Output decode; grant is forced low while reset is held so nothing leaks out.
    always_comb begin
        if (reset) begin
            grant = grant_s;
        end else begin
            grant = 2'b00;
        end
        resp_valid = (state_r == RESP);
        resp_id    = id_r;
        busy       = (state_r != IDLE);
        if (state_r == RESP) begin
            result = count_s;
        end else begin
            result = 4'd0;
        end
    end

endmodule

// File: tb/tb_bca_arbiter.sv
// Scoreboard bench for bca_arbiter: stimulus pushes expected {id,result}, a monitor pops on acceptance.
module tb_bca_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] grant;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [3:0] result;
    logic       busy;

    int         n_checks;
    int         n_fails;
    bit         stim_done;
    logic [4:0] sb_q[$];

    bca_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .grant      (grant),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .result     (result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (grant != 2'b00) begin
                ok = 1;
                break;
            end
        end
    endtask

    // One operation: solo=1 starts on a fresh cycle, drops req after grant and checks IDLE after accept.
    task automatic run_op(input string tag, input logic [1:0] rq, input logic [7:0] d0,
                          input logic [7:0] d1, input bit solo, input logic [1:0] exp_g,
                          input int exp_lat, input logic [3:0] exp_res);
        int ok;
        int lat;
        if (solo) begin
            @(posedge clk); #1;
        end
        req   = rq;
        data0 = d0;
        data1 = d1;
        wait_grant(ok);
        check({tag, " grant_seen"}, ok, 1);
        check({tag, " grant"}, int'(grant), int'(exp_g));
        sb_q.push_back({exp_g[1], exp_res});
        if (solo) begin
            @(posedge clk); #1;
            req = 2'b00;
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        if (solo && resp_ready) begin
            @(negedge clk);
            check({tag, " idle_after_accept"}, int'(busy), 0);
        end
    endtask

    initial begin
        int ok;
        int nvalid;
        n_checks   = 0;
        n_fails    = 0;
        stim_done  = 1'b0;
        reset      = 1'b0;
        req        = 2'b11;
        data0      = 8'h00;
        data1      = 8'h00;
        resp_ready = 1'b1;
        #1;
        check("rst grant", int'(grant), 0);
        check("rst resp_valid", int'(resp_valid), 0);
        check("rst resp_id", int'(resp_id), 0);
        check("rst result", int'(result), 0);
        check("rst busy", int'(busy), 0);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;

        fork
            begin
                logic [4:0] exp;
                while (!stim_done) begin
                    @(negedge clk);
                    if (resp_valid && resp_ready) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_resp", 1, 0);
                        end else begin
                            exp = sb_q.pop_front();
                            check("sb resp_id", int'(resp_id), int'(exp[4]));
                            check("sb result", int'(result), int'(exp[3:0]));
                        end
                    end
                end
            end
            begin
                run_op("op00", 2'b01, 8'h00, 8'h00, 1'b1, 2'b01, 2, 4'd0);
                run_op("opff", 2'b10, 8'h00, 8'hFF, 1'b1, 2'b10, 10, 4'd8);

                // Backpressure in RESP with another request pending.
                @(posedge clk); #1;
                resp_ready = 1'b0;
                req        = 2'b01;
                data0      = 8'h03;
                wait_grant(ok);
                check("bp grant", int'(grant), 1);
                sb_q.push_back({1'b0, 4'd2});
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (resp_valid) break;
                end
                check("bp valid", int'(resp_valid), 1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp hold valid", int'(resp_valid), 1);
                    check("bp hold result", int'(result), 2);
                    check("bp hold id", int'(resp_id), 0);
                    check("bp hold nogrant", int'(grant), 0);
                end
                @(posedge clk); #1;
                resp_ready = 1'b1;
                @(negedge clk);
                check("bp accept nogrant", int'(grant), 0);
                @(negedge clk);
                check("bp regrant", int'(grant), 1);
                sb_q.push_back({1'b0, 4'd2});
                @(posedge clk); #1;
                req = 2'b00;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!busy) break;
                end
                check("bp drain", int'(busy), 0);

                // Reset mid-RUN aborts with no response.
                @(posedge clk); #1;
                req   = 2'b01;
                data0 = 8'hF0;
                wait_grant(ok);
                check("abort grant", int'(grant), 1);
                @(posedge clk); #1;
                req = 2'b00;
                @(posedge clk); #1;
                reset = 1'b0;
                #1;
                check("abort grant0", int'(grant), 0);
                check("abort valid0", int'(resp_valid), 0);
                check("abort result0", int'(result), 0);
                check("abort id0", int'(resp_id), 0);
                check("abort busy0", int'(busy), 0);
                @(posedge clk); #1;
                reset  = 1'b1;
                nvalid = 0;
                for (int i = 0; i < 15; i++) begin
                    @(negedge clk);
                    if (resp_valid || busy) nvalid++;
                end
                check("abort no_resp", nvalid, 0);

                // Contention with both requests held.
                @(posedge clk); #1;
`ifdef BCA_ARB_FIXED_PRIO_EN
                run_op("fp1", 2'b11, 8'h0F, 8'h81, 1'b0, 2'b01, 6, 4'd4);
                run_op("fp2", 2'b11, 8'h0F, 8'h81, 1'b0, 2'b01, 6, 4'd4);
                run_op("fp3", 2'b11, 8'h0F, 8'h81, 1'b0, 2'b01, 6, 4'd4);
`else
                run_op("rr1", 2'b11, 8'h0F, 8'h81, 1'b0, 2'b01, 6, 4'd4);
                run_op("rr2", 2'b11, 8'h0F, 8'h81, 1'b0, 2'b10, 10, 4'd2);
                run_op("rr3", 2'b11, 8'h0F, 8'h81, 1'b0, 2'b01, 6, 4'd4);
`endif
                req = 2'b00;
                repeat (3) @(negedge clk);
                check("final idle", int'(busy), 0);
                stim_done = 1'b1;
            end
        join

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
